iopmp_tl_arbiter: RTL and testbench



---
 rtl/iopmp_tl_arbiter_pkg.sv | 36 +++
 rtl/iopmp_tl_arbiter_if.sv | 62 ++++++
 rtl/iopmp_tl_arbiter_rr_pick.sv | 33 +++
 rtl/iopmp_tl_arbiter.sv | 112 +++++++++++
 tb/tb_iopmp_tl_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iopmp_tl_arbiter_pkg.sv
// Shared definitions for the IOPMP TL-UL request arbiter.
// Holds the master count, the SID width derived from it, the TL-UL field
// widths and opcodes, the arbiter state encoding and a one-hot helper.
package iopmp_tl_arbiter_pkg;

  localparam int NUM_MASTERS = 3;
  localparam int SID_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_SZW = 2;
  localparam int TL_AIW = 8;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // Decode a master index into a one-hot master vector.
  function automatic logic [NUM_MASTERS-1:0] sid_onehot(input logic [SID_W-1:0] sid);
    logic [NUM_MASTERS-1:0] oh;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      oh[i] = (sid == SID_W'(i));
    end
    return oh;
  endfunction

endpackage

// File: rtl/iopmp_tl_arbiter_if.sv
// Bus bundle between the requesting masters, the arbiter and the IOPMP
// checker. Signal suffixes are from the arbiter's point of view.
//   slave  : the arbiter (takes master A requests, drives the checker side)
//   master : the surrounding environment (masters plus downstream checker)
interface iopmp_tl_arbiter_if;
  import iopmp_tl_arbiter_pkg::*;

  // Master-side A channel
  logic [NUM_MASTERS-1:0]             m_a_valid_i;
  logic [NUM_MASTERS-1:0]             m_a_ready_o;
  logic [NUM_MASTERS-1:0][2:0]        m_a_opcode_i;
  logic [NUM_MASTERS-1:0][TL_AW-1:0]  m_a_address_i;
  logic [NUM_MASTERS-1:0][TL_DW-1:0]  m_a_data_i;
  logic [NUM_MASTERS-1:0][TL_DBW-1:0] m_a_mask_i;
  logic [NUM_MASTERS-1:0][TL_SZW-1:0] m_a_size_i;
  logic [NUM_MASTERS-1:0][TL_AIW-1:0] m_a_source_i;
  // Master-side D channel (payload broadcast, valid per master)
  logic [NUM_MASTERS-1:0]             m_d_valid_o;
  logic [NUM_MASTERS-1:0]             m_d_ready_i;
  logic [2:0]                         m_d_opcode_o;
  logic [TL_DW-1:0]                   m_d_data_o;
  logic                               m_d_error_o;
  logic [TL_AIW-1:0]                  m_d_source_o;
  // Downstream A channel
  logic                               dn_a_valid_o;
  logic                               dn_a_ready_i;
  logic [2:0]                         dn_a_opcode_o;
  logic [TL_AW-1:0]                   dn_a_address_o;
  logic [TL_DW-1:0]                   dn_a_data_o;
  logic [TL_DBW-1:0]                  dn_a_mask_o;
  logic [TL_SZW-1:0]                  dn_a_size_o;
  logic [TL_AIW-1:0]                  dn_a_source_o;
  logic [SID_W-1:0]                   sid_o;
  // Downstream D channel
  logic                               dn_d_valid_i;
  logic                               dn_d_ready_o;
  logic [2:0]                         dn_d_opcode_i;
  logic [TL_DW-1:0]                   dn_d_data_i;
  logic                               dn_d_error_i;
  logic [TL_AIW-1:0]                  dn_d_source_i;
  // Status
  logic                               busy_o;

  modport slave (
    input  m_a_valid_i, m_a_opcode_i, m_a_address_i, m_a_data_i, m_a_mask_i,
           m_a_size_i, m_a_source_i, m_d_ready_i, dn_a_ready_i, dn_d_valid_i,
           dn_d_opcode_i, dn_d_data_i, dn_d_error_i, dn_d_source_i,
    output m_a_ready_o, m_d_valid_o, m_d_opcode_o, m_d_data_o, m_d_error_o,
           m_d_source_o, dn_a_valid_o, dn_a_opcode_o, dn_a_address_o, dn_a_data_o,
           dn_a_mask_o, dn_a_size_o, dn_a_source_o, sid_o, dn_d_ready_o, busy_o
  );

  modport master (
    output m_a_valid_i, m_a_opcode_i, m_a_address_i, m_a_data_i, m_a_mask_i,
           m_a_size_i, m_a_source_i, m_d_ready_i, dn_a_ready_i, dn_d_valid_i,
           dn_d_opcode_i, dn_d_data_i, dn_d_error_i, dn_d_source_i,
    input  m_a_ready_o, m_d_valid_o, m_d_opcode_o, m_d_data_o, m_d_error_o,
           m_d_source_o, dn_a_valid_o, dn_a_opcode_o, dn_a_address_o, dn_a_data_o,
           dn_a_mask_o, dn_a_size_o, dn_a_source_o, sid_o, dn_d_ready_o, busy_o
  );

endinterface

// File: rtl/iopmp_tl_arbiter_rr_pick.sv
// iopmp_rr_pick: combinational round-robin picker.
// Ports:
//   req_i  : request vector
//   ptr_i  : highest-priority index (search starts here and wraps)
//   idx_o  : index of the first set request at or after ptr_i
//   any_o  : at least one request is set
module iopmp_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Scan from the farthest candidate to the nearest so the nearest set
  // request (closest to ptr_i, wrapping) is the last one to overwrite idx_o.
  always_comb begin
    int unsigned start_v;
    int unsigned cand_v;
    idx_o   = '0;
    any_o   = 1'b0;
    start_v = (32'(ptr_i) < NUM_REQ) ? 32'(ptr_i) : 32'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_v = start_v + 32'(k);
      cand_v = (cand_v >= NUM_REQ) ? cand_v - NUM_REQ : cand_v;
      idx_o  = req_i[cand_v] ? IDX_W'(cand_v) : idx_o;
      any_o  = any_o | req_i[cand_v];
    end
  end

endmodule

// File: rtl/iopmp_tl_arbiter.sv
// iopmp_tl_arbiter: round-robin arbiter sharing one TL-UL path into the
// IOPMP checker between NUM_MASTERS requesters, one transaction in flight.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : iopmp_tl_arbiter_if.slave (master A/D, downstream A/D,
//                  sid_o with the granted master index, busy_o)
module iopmp_tl_arbiter
  import iopmp_tl_arbiter_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  iopmp_tl_arbiter_if.slave  bus
);

  arb_state_t             state_q, state_d;
  logic [SID_W-1:0]       owner_q, owner_d;
  logic [SID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [SID_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] owner_oh;

  iopmp_rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (SID_W)
  ) u_rr_pick (
    .req_i (bus.m_a_valid_i),
    .ptr_i (rr_ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign owner_oh = sid_onehot(owner_q);

  // A payload always follows the owner; only dn_a_valid_o is qualified by state.
  assign bus.dn_a_opcode_o  = bus.m_a_opcode_i[owner_q];
  assign bus.dn_a_address_o = bus.m_a_address_i[owner_q];
  assign bus.dn_a_data_o    = bus.m_a_data_i[owner_q];
  assign bus.dn_a_mask_o    = bus.m_a_mask_i[owner_q];
  assign bus.dn_a_size_o    = bus.m_a_size_i[owner_q];
  assign bus.dn_a_source_o  = bus.m_a_source_i[owner_q];

  // D payload is broadcast; only the owner sees m_d_valid_o.
  assign bus.m_d_opcode_o   = bus.dn_d_opcode_i;
  assign bus.m_d_data_o     = bus.dn_d_data_i;
  assign bus.m_d_error_o    = bus.dn_d_error_i;
  assign bus.m_d_source_o   = bus.dn_d_source_i;

  assign bus.busy_o = (state_q != ARB_IDLE);

  // Next-state and handshake steering.
  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    rr_ptr_d         = rr_ptr_q;
    bus.m_a_ready_o  = '0;
    bus.m_d_valid_o  = '0;
    bus.dn_a_valid_o = 1'b0;
    bus.dn_d_ready_o = 1'b0;
    bus.sid_o        = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = ARB_REQ;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_REQ: begin
        bus.sid_o        = owner_q;
        bus.dn_a_valid_o = bus.m_a_valid_i[owner_q];
        bus.m_a_ready_o  = owner_oh & {NUM_MASTERS{bus.dn_a_ready_i}};
        // A withdrawn request is abandoned without advancing the pointer.
        if (!bus.m_a_valid_i[owner_q]) begin
          state_d = ARB_IDLE;
        end else if (bus.dn_a_ready_i) begin
          state_d = ARB_RESP;
        end else begin
          state_d = ARB_REQ;
        end
      end
      ARB_RESP: begin
        bus.sid_o        = owner_q;
        bus.m_d_valid_o  = owner_oh & {NUM_MASTERS{bus.dn_d_valid_i}};
        bus.dn_d_ready_o = bus.m_d_ready_i[owner_q];
        if (bus.dn_d_valid_i && bus.m_d_ready_i[owner_q]) begin
          rr_ptr_d = (owner_q == SID_W'(NUM_MASTERS - 1)) ? SID_W'(0) : owner_q + SID_W'(1);
          state_d  = ARB_IDLE;
        end else begin
          state_d  = ARB_RESP;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State, owner and round-robin pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_iopmp_tl_arbiter.sv
// Self-checking bench for iopmp_tl_arbiter: a cycle table, directed corner
// sequences and a randomized run checked against a transaction-level model.
module tb_iopmp_tl_arbiter;
  import iopmp_tl_arbiter_pkg::*;

  localparam int N = NUM_MASTERS;

  logic clk_i;
  logic rst_i;
  iopmp_tl_arbiter_if bus_if ();

  iopmp_tl_arbiter dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0]     a_valid;
    logic             busy;
    logic [SID_W-1:0] sid;
    logic             dn_a_valid;
    logic [N-1:0]     a_ready;
    logic [N-1:0]     d_valid;
    logic             dn_d_ready;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] m_addr[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ctl_act();
    return 64'({bus_if.busy_o, bus_if.dn_a_valid_o, bus_if.m_a_ready_o,
                bus_if.m_d_valid_o, bus_if.dn_d_ready_o});
  endfunction

  function automatic logic [63:0] ctl_exp(input logic busy, input logic dav,
                                          input logic [N-1:0] ar, input logic [N-1:0] dv,
                                          input logic ddr);
    return 64'({busy, dav, ar, dv, ddr});
  endfunction

  function automatic vec_t mk(input logic [N-1:0] av, input logic b, input int s,
                              input logic dav, input logic [N-1:0] ar,
                              input logic [N-1:0] dv, input logic ddr);
    vec_t v;
    v.a_valid = av; v.busy = b; v.sid = SID_W'(s); v.dn_a_valid = dav;
    v.a_ready = ar; v.d_valid = dv; v.dn_d_ready = ddr;
    return v;
  endfunction

  // Round-robin rule: first requester at or after ptr, wrapping.
  function automatic int rr_winner(input logic [N-1:0] req, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic set_master(input int i, input logic [2:0] op, input logic [31:0] addr,
                            input logic [7:0] src);
    bus_if.m_a_opcode_i[i]  = op;
    bus_if.m_a_address_i[i] = addr;
    bus_if.m_a_data_i[i]    = addr ^ 32'h5A5A_5A5A;
    bus_if.m_a_mask_i[i]    = 4'hF;
    bus_if.m_a_size_i[i]    = 2'd2;
    bus_if.m_a_source_i[i]  = src;
  endtask

  task automatic idle_inputs();
    bus_if.m_a_valid_i   = '0;
    bus_if.m_d_ready_i   = '0;
    bus_if.dn_a_ready_i  = 1'b0;
    bus_if.dn_d_valid_i  = 1'b0;
    bus_if.dn_d_opcode_i = AccessAckData;
    bus_if.dn_d_data_i   = 32'hCAFE_0001;
    bus_if.dn_d_error_i  = 1'b0;
    bus_if.dn_d_source_i = 8'h00;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Randomized-run state
  logic [N-1:0] pend;
  logic [31:0]  r_addr[N];
  logic [7:0]   r_src[N];
  int           issued[N];
  int           served[N];
  bit           m_busy, m_in_a;
  int           m_owner, m_ptr;
  logic [N-1:0] oh;
  logic [31:0]  exp_rdata;
  logic [7:0]   exp_rsrc;
  bit           rsp_pend;
  logic [31:0]  rsp_data;
  logic [7:0]   rsp_src;
  logic         rsp_err;

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    m_addr[0] = 32'h0000_0800;
    m_addr[1] = 32'h0000_1000;
    m_addr[2] = 32'h0000_2000;
    for (int i = 0; i < N; i++) begin
      set_master(i, PutFullData, m_addr[i], 8'(i + 1));
      issued[i] = 0;
      served[i] = 0;
    end
    set_master(1, Get, m_addr[1], 8'h02);
    set_master(2, PutPartialData, m_addr[2], 8'h03);

    // ---- Cycle table: all three requesting from pointer 0, then m1 alone,
    //      then a wrap from pointer 2 with m0 and m2 requesting.
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] toh;
      toh = '0;
      toh[k % N] = 1'b1;
      tbl.push_back(mk(3'b111, 1'b0, 0,     1'b0, 3'b000, 3'b000, 1'b0));
      tbl.push_back(mk(3'b111, 1'b1, k % N, 1'b1, toh,    3'b000, 1'b0));
      tbl.push_back(mk(3'b111, 1'b1, k % N, 1'b0, 3'b000, toh,    1'b1));
    end
    tbl.push_back(mk(3'b010, 1'b0, 0, 1'b0, 3'b000, 3'b000, 1'b0));
    tbl.push_back(mk(3'b010, 1'b1, 1, 1'b1, 3'b010, 3'b000, 1'b0));
    tbl.push_back(mk(3'b000, 1'b1, 1, 1'b0, 3'b000, 3'b010, 1'b1));
    tbl.push_back(mk(3'b101, 1'b0, 0, 1'b0, 3'b000, 3'b000, 1'b0));
    tbl.push_back(mk(3'b101, 1'b1, 2, 1'b1, 3'b100, 3'b000, 1'b0));
    tbl.push_back(mk(3'b001, 1'b1, 2, 1'b0, 3'b000, 3'b100, 1'b1));
    tbl.push_back(mk(3'b001, 1'b0, 0, 1'b0, 3'b000, 3'b000, 1'b0));
    tbl.push_back(mk(3'b001, 1'b1, 0, 1'b1, 3'b001, 3'b000, 1'b0));
    tbl.push_back(mk(3'b000, 1'b1, 0, 1'b0, 3'b000, 3'b001, 1'b1));
    tbl.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000, 3'b000, 1'b0));

    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("reset_ctl", ctl_act(), 64'd0);
    check("reset_sid", 64'(bus_if.sid_o), 64'd0);
    cyc();

    bus_if.dn_a_ready_i = 1'b1;
    bus_if.dn_d_valid_i = 1'b1;
    bus_if.m_d_ready_i  = '1;
    for (int r = 0; r < tbl.size(); r++) begin
      bus_if.m_a_valid_i = tbl[r].a_valid;
      @(negedge clk_i);
      check($sformatf("tbl%0d_ctl", r), ctl_act(),
            ctl_exp(tbl[r].busy, tbl[r].dn_a_valid, tbl[r].a_ready, tbl[r].d_valid, tbl[r].dn_d_ready));
      if (tbl[r].busy) check($sformatf("tbl%0d_sid", r), 64'(bus_if.sid_o), 64'(tbl[r].sid));
      if (tbl[r].dn_a_valid) begin
        check($sformatf("tbl%0d_addr", r), 64'(bus_if.dn_a_address_o), 64'(m_addr[tbl[r].sid]));
        if (tbl[r].sid == SID_W'(1)) check($sformatf("tbl%0d_op", r), 64'(bus_if.dn_a_opcode_o), 64'(Get));
      end
      cyc();
    end

    // ---- Backpressure: A stalled 5 cycles, D stalled by the master 4 cycles.
    do_reset();
    bus_if.m_a_valid_i  = 3'b001;
    bus_if.dn_d_valid_i = 1'b1;
    bus_if.m_d_ready_i  = 3'b111;
    @(negedge clk_i);
    check("bp_arb", ctl_act(), ctl_exp(1'b0, 1'b0, 3'b000, 3'b000, 1'b0));
    cyc();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("bp_a%0d_ctl", c), ctl_act(), ctl_exp(1'b1, 1'b1, 3'b000, 3'b000, 1'b0));
      check($sformatf("bp_a%0d_fld", c), {bus_if.dn_a_address_o, 30'd0, bus_if.sid_o},
            {m_addr[0], 32'd0});
      cyc();
    end
    bus_if.dn_a_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_a_hs", ctl_act(), ctl_exp(1'b1, 1'b1, 3'b001, 3'b000, 1'b0));
    cyc();
    bus_if.m_a_valid_i  = 3'b000;
    bus_if.dn_a_ready_i = 1'b0;
    bus_if.m_d_ready_i  = 3'b110;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      check($sformatf("bp_d%0d_ctl", c), ctl_act(), ctl_exp(1'b1, 1'b0, 3'b000, 3'b001, 1'b0));
      cyc();
    end
    bus_if.m_d_ready_i = 3'b111;
    @(negedge clk_i);
    check("bp_d_hs", ctl_act(), ctl_exp(1'b1, 1'b0, 3'b000, 3'b001, 1'b1));
    cyc();
    bus_if.dn_d_valid_i = 1'b0;
    @(negedge clk_i);
    check("bp_done", ctl_act(), 64'd0);
    cyc();

    // ---- Error pass-through for m2's PutFullData; pointer then wraps to 0.
    set_master(2, PutFullData, 32'h2000_0040, 8'h07);
    bus_if.m_a_valid_i  = 3'b100;
    bus_if.dn_a_ready_i = 1'b1;
    @(negedge clk_i);
    cyc();
    @(negedge clk_i);
    check("err_req_sid", 64'(bus_if.sid_o), 64'd2);
    check("err_req_op", 64'(bus_if.dn_a_opcode_o), 64'(PutFullData));
    cyc();
    bus_if.m_a_valid_i   = 3'b011;
    bus_if.dn_d_valid_i  = 1'b1;
    bus_if.dn_d_error_i  = 1'b1;
    bus_if.dn_d_source_i = 8'h2A;
    bus_if.dn_d_opcode_i = AccessAck;
    @(negedge clk_i);
    check("err_resp_ctl", ctl_act(), ctl_exp(1'b1, 1'b0, 3'b000, 3'b100, 1'b1));
    check("err_resp_fld", 64'({bus_if.m_d_error_o, bus_if.m_d_source_o, bus_if.m_d_opcode_o}),
          64'({1'b1, 8'h2A, AccessAck}));
    cyc();
    bus_if.dn_d_valid_i = 1'b0;
    bus_if.dn_d_error_i = 1'b0;
    @(negedge clk_i);
    check("err_next_idle", 64'(bus_if.busy_o), 64'd0);
    cyc();
    @(negedge clk_i);
    check("err_next_sid", 64'(bus_if.sid_o), 64'd0);

    // ---- Reset asserted while waiting for the response.
    do_reset();
    bus_if.m_a_valid_i  = 3'b010;
    bus_if.dn_a_ready_i = 1'b1;
    @(negedge clk_i);
    cyc();
    @(negedge clk_i);
    cyc();
    bus_if.m_a_valid_i = 3'b000;
    @(negedge clk_i);
    check("rst_in_resp", ctl_act(), ctl_exp(1'b1, 1'b0, 3'b000, 3'b000, 1'b0));
    #1;
    bus_if.dn_d_valid_i = 1'b1;
    bus_if.m_d_ready_i  = 3'b111;
    #1;
    check("rst_pre", ctl_act(), ctl_exp(1'b1, 1'b0, 3'b000, 3'b010, 1'b1));
    rst_i = 1'b1;
    #1;
    check("rst_async_ctl", ctl_act(), 64'd0);
    check("rst_async_sid", 64'(bus_if.sid_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    bus_if.dn_d_valid_i = 1'b0;
    bus_if.m_a_valid_i  = 3'b110;
    @(negedge clk_i);
    check("rst_after_idle", 64'(bus_if.busy_o), 64'd0);
    cyc();
    @(negedge clk_i);
    check("rst_after_grant", 64'({bus_if.dn_a_valid_o, bus_if.sid_o}), 64'({1'b1, SID_W'(1)}));

    // ---- Randomized run against a transaction-level model.
    do_reset();
    pend = '0; m_busy = 0; m_in_a = 0; m_owner = 0; m_ptr = 0; rsp_pend = 0;
    rsp_data = '0; rsp_src = '0; rsp_err = 1'b0; exp_rdata = '0; exp_rsrc = '0;
    for (int c = 0; c < 3000; c++) begin
      bit drain;
      drain = (c >= 2900);
      for (int i = 0; i < N; i++) begin
        if (!drain && !pend[i] && $urandom_range(3) == 0) begin
          logic [2:0] op;
          op = ($urandom_range(2) == 0) ? Get : (($urandom_range(1) == 0) ? PutFullData : PutPartialData);
          pend[i]   = 1'b1;
          r_addr[i] = $urandom & 32'hFFFF_FFFC;
          r_src[i]  = 8'($urandom);
          issued[i]++;
          set_master(i, op, r_addr[i], r_src[i]);
        end
      end
      bus_if.m_a_valid_i   = pend;
      bus_if.dn_a_ready_i  = drain ? 1'b1 : 1'($urandom);
      bus_if.m_d_ready_i   = drain ? '1 : N'($urandom);
      bus_if.dn_d_valid_i  = rsp_pend & (drain ? 1'b1 : 1'($urandom));
      bus_if.dn_d_data_i   = rsp_data;
      bus_if.dn_d_source_i = rsp_src;
      bus_if.dn_d_error_i  = rsp_err;
      bus_if.dn_d_opcode_i = AccessAckData;
      @(negedge clk_i);
      if (!m_busy) begin
        check("rnd_idle", ctl_act(), 64'd0);
        if (|pend) begin
          m_owner = rr_winner(pend, m_ptr);
          m_busy  = 1;
          m_in_a  = 1;
        end
      end else begin
        oh = '0;
        oh[m_owner] = 1'b1;
        check("rnd_sid", 64'(bus_if.sid_o), 64'(m_owner));
        if (m_in_a) begin
          check("rnd_a_ctl", ctl_act(),
                ctl_exp(1'b1, 1'b1, bus_if.dn_a_ready_i ? oh : '0, '0, 1'b0));
          check("rnd_a_fld", {bus_if.dn_a_address_o, 24'd0, bus_if.dn_a_source_o},
                {r_addr[m_owner], 24'd0, r_src[m_owner]});
          if (bus_if.dn_a_ready_i) begin
            pend[m_owner] = 1'b0;
            exp_rdata     = ~r_addr[m_owner];
            exp_rsrc      = r_src[m_owner];
            m_in_a        = 0;
          end
        end else begin
          check("rnd_d_ctl", ctl_act(),
                ctl_exp(1'b1, 1'b0, '0, bus_if.dn_d_valid_i ? oh : '0, bus_if.m_d_ready_i[m_owner]));
          if (bus_if.dn_d_valid_i && bus_if.m_d_ready_i[m_owner]) begin
            check("rnd_d_fld", {bus_if.m_d_data_o, 24'd0, bus_if.m_d_source_o},
                  {exp_rdata, 24'd0, exp_rsrc});
            served[m_owner]++;
            m_ptr  = (m_owner + 1) % N;
            m_busy = 0;
          end
        end
      end
      // Downstream device: answer each accepted A with a response derived from it.
      if (bus_if.dn_d_valid_i && bus_if.dn_d_ready_o) rsp_pend = 0;
      if (bus_if.dn_a_valid_o && bus_if.dn_a_ready_i) begin
        rsp_pend = 1;
        rsp_data = ~bus_if.dn_a_address_o;
        rsp_src  = bus_if.dn_a_source_o;
        rsp_err  = 1'($urandom);
      end
      cyc();
    end
    for (int i = 0; i < N; i++) begin
      check($sformatf("rnd_served_m%0d", i), 64'(served[i]), 64'(issued[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
